// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  // Bytes per word; the word width is an integer multiple of the byte width.
  function automatic int calc_bpw(input int nb_data, input int nb_byte);
    return nb_data / nb_byte;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Synchronous 1R1W word array with registered read port.
module instr_mem_array #(
  parameter int    NB_DATA   = 32,
  parameter int    N_WORDS   = 128,
  parameter int    NB_ADDR   = 7,
  parameter string INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [NB_ADDR-1:0] waddr,
  input  logic [NB_DATA-1:0] wdata,
  input  logic               re,
  input  logic [NB_ADDR-1:0] raddr,
  output logic [NB_DATA-1:0] rdata
);

  localparam bit POW2 = (N_WORDS == (1 << NB_ADDR));

  logic [NB_DATA-1:0] mem [N_WORDS];
  logic               in_range;

  // Addresses past the end of a non-power-of-2 array read as zero.
  assign in_range = POW2 || (int'(raddr) < N_WORDS);

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= in_range ? mem[raddr] : '0;
  end

endmodule

// File: rtl/instr_memory_loader.sv
// Instruction memory with a byte-stream loader (MSB first) and a gated 1-cycle fetch port.
module instr_memory_loader
  import instr_mem_pkg::*;
#(
  parameter int                     NB_DATA_BUS = 32,
  parameter int                     NB_BYTE     = 8,
  parameter int                     N_ADDRESS   = 128,
  parameter int                     NB_ADDRESS  = $clog2(N_ADDRESS),
  parameter logic [NB_DATA_BUS-1:0] HALT_WORD   = NB_DATA_BUS'(DEFAULT_HALT_WORD),
  parameter string                  INIT_FILE   = ""
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_load_start,
  input  logic                   i_byte_valid,
  input  logic [NB_BYTE-1:0]     i_byte,
  output logic                   o_byte_ready,
  output logic                   o_load_busy,
  output logic                   o_load_done,
  output logic                   o_load_overflow,
  output logic [NB_ADDRESS:0]    o_load_count,
  input  logic [NB_ADDRESS-1:0]  i_r_addr,
  input  logic                   i_r_en,
  output logic [NB_DATA_BUS-1:0] o_r_data,
  output logic                   o_r_valid
);

  localparam int                  BPW        = calc_bpw(NB_DATA_BUS, NB_BYTE);
  localparam int                  NB_BCNT    = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [NB_BCNT-1:0]  LAST_BYTE  = NB_BCNT'(BPW - 1);
  localparam logic [NB_ADDRESS:0] FULL_COUNT = (NB_ADDRESS + 1)'(N_ADDRESS);

  load_state_t            state;
  logic [NB_BCNT-1:0]     byte_cnt;
  logic [NB_DATA_BUS-1:0] shift_reg;
  logic [NB_DATA_BUS-1:0] word;
  logic                   accept;
  logic                   commit;
  logic                   rd_en;

  assign accept = (state == LOAD) && i_byte_valid;
  assign commit = accept && (byte_cnt == LAST_BYTE);
  // The final byte is written in the same edge it arrives, so bypass the shift register.
  assign word   = {shift_reg[NB_DATA_BUS-NB_BYTE-1:0], i_byte};
  assign rd_en  = i_r_en && (state != LOAD);

  assign o_byte_ready = (state == LOAD);
  assign o_load_busy  = (state == LOAD);
  assign o_load_done  = (state == DONE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= IDLE;
      byte_cnt        <= '0;
      shift_reg       <= '0;
      o_load_count    <= '0;
      o_load_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_load_start) begin
            state           <= LOAD;
            byte_cnt        <= '0;
            o_load_count    <= '0;
            o_load_overflow <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            shift_reg <= word;
            if (commit) begin
              byte_cnt     <= '0;
              o_load_count <= o_load_count + 1'b1;
              if (word == HALT_WORD) begin
                state <= DONE;
              end else if (o_load_count + 1'b1 == FULL_COUNT) begin
                state           <= DONE;
                o_load_overflow <= 1'b1;
              end
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_r_valid <= 1'b0;
    else       o_r_valid <= rd_en;
  end

  instr_mem_array #(
    .NB_DATA   (NB_DATA_BUS),
    .N_WORDS   (N_ADDRESS),
    .NB_ADDR   (NB_ADDRESS),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk   (i_clk),
    .rst   (i_rst),
    .we    (commit),
    .waddr (o_load_count[NB_ADDRESS-1:0]),
    .wdata (word),
    .re    (rd_en),
    .raddr (i_r_addr),
    .rdata (o_r_data)
  );

endmodule

// File: tb/tb_instr_memory_loader.sv
// Bench for instr_memory_loader: constant vector table, directed corner sequences, random vs. model.
module tb_instr_memory_loader;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 0, byte_valid = 0, r_en = 0;
  logic [7:0]  bt = '0;
  logic [6:0]  r_addr = '0;
  logic        byte_ready, load_busy, load_done, load_ovf, r_valid;
  logic [7:0]  load_count;
  logic [31:0] r_data;

  // Small-depth instances: depth 4 (power of 2) and depth 5 (out-of-range reads).
  logic        ld4 = 0, bv4 = 0, ren4 = 0;
  logic [7:0]  b4 = '0;
  logic [1:0]  ra4 = '0;
  logic [2:0]  ra5 = '0;
  logic        rdy4, busy4, done4, ovf4, rv4, rdy5, busy5, done5, ovf5, rv5;
  logic [2:0]  cnt4;
  logic [3:0]  cnt5;
  logic [31:0] rd4, rd5;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  instr_memory_loader dut (
    .i_clk(clk), .i_rst(rst), .i_load_start(load_start), .i_byte_valid(byte_valid), .i_byte(bt),
    .o_byte_ready(byte_ready), .o_load_busy(load_busy), .o_load_done(load_done),
    .o_load_overflow(load_ovf), .o_load_count(load_count), .i_r_addr(r_addr), .i_r_en(r_en),
    .o_r_data(r_data), .o_r_valid(r_valid));

  instr_memory_loader #(.N_ADDRESS(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_load_start(ld4), .i_byte_valid(bv4), .i_byte(b4),
    .o_byte_ready(rdy4), .o_load_busy(busy4), .o_load_done(done4), .o_load_overflow(ovf4),
    .o_load_count(cnt4), .i_r_addr(ra4), .i_r_en(ren4), .o_r_data(rd4), .o_r_valid(rv4));

  instr_memory_loader #(.N_ADDRESS(5)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_load_start(ld4), .i_byte_valid(bv4), .i_byte(b4),
    .o_byte_ready(rdy5), .o_load_busy(busy5), .o_load_done(done5), .o_load_overflow(ovf5),
    .o_load_count(cnt5), .i_r_addr(ra5), .i_r_en(ren4), .o_r_data(rd5), .o_r_valid(rv5));

  // Reference model of the depth-128 instance: byte queue, word array, load flags.
  logic [31:0] m_mem [128];
  bit          m_known [128];
  logic [7:0]  m_bytes [$];
  bit          m_load, m_done, m_ovf, m_rvalid, m_rknown;
  int          m_count;
  logic [31:0] m_rdata;

  task automatic model_reset();
    m_load = 0; m_done = 0; m_ovf = 0; m_count = 0; m_bytes.delete();
    m_rvalid = 0; m_rdata = '0; m_rknown = 1;
  endtask

  task automatic model_step();
    logic [31:0] w;
    if (r_en && !m_load) begin
      m_rvalid = 1; m_rdata = m_mem[r_addr]; m_rknown = m_known[r_addr];
    end else begin
      m_rvalid = 0;
    end
    if (m_load) begin
      if (byte_valid) begin
        m_bytes.push_back(bt);
        if (m_bytes.size() == 4) begin
          w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
          m_bytes.delete();
          m_mem[m_count] = w; m_known[m_count] = 1; m_count++;
          if (w == HALT) begin m_load = 0; m_done = 1; end
          else if (m_count == 128) begin m_load = 0; m_done = 1; m_ovf = 1; end
        end
      end
    end else if (load_start) begin
      m_load = 1; m_done = 0; m_ovf = 0; m_count = 0; m_bytes.delete();
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drv(input bit s, input bit v, input logic [7:0] b, input bit re, input logic [6:0] a);
    load_start = s; byte_valid = v; bt = b; r_en = re; r_addr = a;
  endtask

  task automatic pulse_reset();
    rst = 1; #2;
    model_reset();
    chk("reset_status", {load_busy, load_done, load_ovf, byte_ready, r_valid, load_count}, '0);
    chk("reset_rdata", r_data, '0);
    rst = 0;
  endtask

  typedef struct {
    logic        s, v;
    logic [7:0]  b;
    logic        re;
    logic [6:0]  a;
    logic        busy, done;
    logic [7:0]  cnt;
    logic        rv;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(logic s, logic v, logic [7:0] b, logic re, logic [6:0] a,
                              logic busy, logic done, logic [7:0] cnt, logic rv, logic [31:0] rd);
    vec_t t;
    t.s = s; t.v = v; t.b = b; t.re = re; t.a = a;
    t.busy = busy; t.done = done; t.cnt = cnt; t.rv = rv; t.rd = rd;
    return t;
  endfunction

  vec_t tbl [$];

  initial begin
    logic [7:0]  plan [$];
    logic [31:0] w;
    int          nw;

    // Load 00000001 + HALT, read both back, then a load with blocked reads and ignored starts.
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0, 1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0, 1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0, 1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 8'h01, 0, 0, 1, 0, 1, 0, 32'h0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 1, 0, 1, 0, 32'h0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 1, 0, 1, 0, 32'h0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 1, 0, 1, 0, 32'h0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 0, 1, 2, 0, 32'h0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 2, 1, 32'h1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 1, 2, 1, HALT));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 2, 0, HALT));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 1, 0, 0, 0, HALT));
    tbl.push_back(mk(0, 1, 8'hAA, 1, 0, 1, 0, 0, 0, HALT));
    tbl.push_back(mk(1, 1, 8'hBB, 1, 0, 1, 0, 0, 0, HALT));
    tbl.push_back(mk(1, 1, 8'hCC, 1, 1, 1, 0, 0, 0, HALT));
    tbl.push_back(mk(0, 1, 8'hDD, 1, 1, 1, 0, 1, 0, HALT));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 1, 0, 1, 0, HALT));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 1, 0, 1, 0, HALT));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 1, 0, 1, 0, HALT));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 0, 1, 2, 0, HALT));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 2, 1, 32'hAABBCCDD));

    repeat (2) @(posedge clk);
    #1;
    pulse_reset();
    chk("reset_dut4", {busy4, done4, ovf4, rdy4, rv4, cnt4}, '0);

    foreach (tbl[i]) begin
      drv(tbl[i].s, tbl[i].v, tbl[i].b, tbl[i].re, tbl[i].a);
      cyc();
      chk($sformatf("tbl[%0d] status", i), {load_busy, load_done, load_ovf, byte_ready, load_count},
          {tbl[i].busy, tbl[i].done, 1'b0, tbl[i].busy, tbl[i].cnt});
      chk($sformatf("tbl[%0d] read", i), {r_valid, r_data}, {tbl[i].rv, tbl[i].rd});
    end

    // Valid toggling every cycle: 4 accepts per word.
    drv(1, 0, 0, 0, 0); cyc();
    chk("t6_start", {load_busy, load_count}, {1'b1, 8'd0});
    for (int i = 0; i < 16; i++) begin
      drv(0, (i % 2) == 0, 8'(8'h10 + i), 0, 0); cyc();
      chk($sformatf("t6_cnt[%0d]", i), {byte_ready, load_count}, {1'b1, 8'(((i / 2) + 1) / 4)});
    end
    for (int i = 0; i < 4; i++) begin drv(0, 1, 8'hFF, 0, 0); cyc(); end
    chk("t6_done", {load_busy, load_done, load_count}, {1'b0, 1'b1, 8'd3});
    drv(0, 0, 0, 1, 0); cyc(); chk("t6_rd0", r_data, 32'h10121416);
    drv(0, 0, 0, 1, 1); cyc(); chk("t6_rd1", r_data, 32'h181A1C1E);

    // Reset mid-word, then a fresh HALT-only load.
    drv(1, 0, 0, 0, 0); cyc();
    drv(0, 1, 8'h12, 0, 0); cyc();
    drv(0, 1, 8'h34, 0, 0); cyc();
    drv(0, 1, 8'h56, 0, 0); cyc();
    drv(0, 0, 0, 0, 0);
    pulse_reset();
    drv(1, 0, 0, 0, 0); cyc();
    for (int i = 0; i < 4; i++) begin drv(0, 1, 8'hFF, 0, 0); cyc(); end
    chk("t4_done", {load_busy, load_done, load_ovf, load_count}, {1'b0, 1'b1, 1'b0, 8'd1});
    drv(0, 0, 0, 1, 0); cyc(); chk("t4_rd0", {r_valid, r_data}, {1'b1, HALT});
    drv(0, 0, 0, 1, 1); cyc(); chk("t4_rd1_kept", r_data, 32'h181A1C1E);
    drv(0, 0, 0, 0, 0);

    // Fill depth-4 memory; depth-5 instance fills one word later.
    ld4 = 1; cyc(); ld4 = 0;
    for (int i = 0; i < 20; i++) begin
      bv4 = 1; b4 = 8'h11; cyc();
      if (i == 14) chk("t3_pre_full", {busy4, done4, cnt4}, {1'b1, 1'b0, 3'd3});
      if (i == 15) chk("t3_full", {busy4, done4, ovf4, rdy4, cnt4}, {1'b0, 1'b1, 1'b1, 1'b0, 3'd4});
    end
    bv4 = 0;
    chk("t3_dropped", {done4, ovf4, cnt4}, {1'b1, 1'b1, 3'd4});
    chk("t3_dut5_full", {done5, ovf5, cnt5}, {1'b1, 1'b1, 4'd5});
    ren4 = 1;
    for (int a = 0; a < 4; a++) begin
      ra4 = 2'(a); ra5 = 3'(a + 4); cyc();
      chk($sformatf("t3_rd[%0d]", a), {rv4, rd4}, {1'b1, 32'h11111111});
      chk($sformatf("t3_oor[%0d]", a + 4), {rv5, rd5}, {1'b1, (a == 0) ? 32'h11111111 : 32'h0});
    end
    ren4 = 0;

    // Randomized loads, reads, restarts and resets against the model.
    for (int c = 0; c < 6000; c++) begin
      drv(0, 0, 8'($urandom), $urandom_range(0, 1), 7'($urandom));
      if (!m_load) begin
        if ($urandom_range(0, 5) == 0) begin
          load_start = 1;
          plan.delete();
          nw = ($urandom_range(0, 3) == 0) ? 135 : $urandom_range(0, 5);
          for (int k = 0; k < nw; k++) begin
            w = $urandom;
            if (w == HALT) w = '0;
            for (int j = 3; j >= 0; j--) plan.push_back(w[j*8 +: 8]);
          end
          for (int j = 0; j < 4; j++) plan.push_back(8'hFF);
        end else begin
          byte_valid = $urandom_range(0, 1);
        end
      end else begin
        load_start = ($urandom_range(0, 15) == 0);
        byte_valid = ($urandom_range(0, 3) != 0);
        if (byte_valid && plan.size() > 0) bt = plan.pop_front();
      end
      cyc();
      chk("rand_status", {load_busy, load_done, load_ovf, byte_ready, r_valid, load_count},
          {m_load, m_done, m_ovf, m_load, m_rvalid, 8'(m_count)});
      if (m_rknown) chk("rand_rdata", r_data, m_rdata);
      if ($urandom_range(0, 699) == 0) pulse_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
